// File: rtl/affine_scan_pkg.sv
// affine_scan_pkg: shared state encoding, default widths and address helper for the affine scanners
package affine_scan_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Callers truncate the result to their own address width, which keeps the sum modulo 2^ADDR_W.
    function automatic logic [31:0] affine_sum(input logic [31:0] offset, input logic [31:0] x_acc,
                                               input logic [31:0] y_acc);
        return offset + x_acc + y_acc;
    endfunction

endpackage

// File: rtl/affine_scan_wr_stage.sv
// affine_scan_wr_stage: single-entry write request register with valid/ready hold
module affine_scan_wr_stage #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              wr_ready,
    output logic              can_load,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    assign can_load = !wr_valid || wr_ready;

    // Load a new request, otherwise hold it until the memory side takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else if (load) begin
            wr_valid <= 1'b1;
            wr_addr  <= load_addr;
            wr_data  <= load_data;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/affine_scan_writer.sv
// affine_scan_writer: writes a streamed frame to memory in raster affine address order
// Optional feature macro AFFINE_SCAN_WR_LAST_CHECK_EN adds in_last checking with a sticky err output.
module affine_scan_writer
    import affine_scan_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  x_max,
    input  logic [CNT_W-1:0]  y_max,
    input  logic [ADDR_W-1:0] x_stride,
    input  logic [ADDR_W-1:0] y_stride,
    input  logic [ADDR_W-1:0] offset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
`ifdef AFFINE_SCAN_WR_LAST_CHECK_EN
    ,
    input  logic              in_last,
    output logic              err
`endif
);

    state_t            state;
    logic [CNT_W-1:0]  x, y, cx, cy;
    logic [ADDR_W-1:0] x_acc, y_acc, cxs, cys, coff, sum;
    logic              can_load, accept, last_x, last_y;

    assign in_ready = (state == RUN) && can_load;
    assign accept   = in_valid && in_ready;
    assign last_x   = x == cx - CNT_W'(1);
    assign last_y   = y == cy - CNT_W'(1);
    assign sum      = ADDR_W'(affine_sum(32'(coff), 32'(x_acc), 32'(y_acc)));
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = state == FIN;

    affine_scan_wr_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_addr (sum),
        .load_data (in_data),
        .wr_ready  (wr_ready),
        .can_load  (can_load),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Frame sequencing and raster counters; empty frames pass through DRAIN so busy shows for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            x_acc <= '0;
            y_acc <= '0;
            cx    <= '0;
            cy    <= '0;
            cxs   <= '0;
            cys   <= '0;
            coff  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cx    <= x_max;
                    cy    <= y_max;
                    cxs   <= x_stride;
                    cys   <= y_stride;
                    coff  <= offset;
                    x     <= '0;
                    y     <= '0;
                    x_acc <= '0;
                    y_acc <= '0;
                    state <= (x_max == '0 || y_max == '0) ? DRAIN : RUN;
                end
                RUN: if (accept) begin
                    if (!last_x) begin
                        x     <= x + CNT_W'(1);
                        x_acc <= x_acc + cxs;
                    end else begin
                        x     <= '0;
                        x_acc <= '0;
                        y     <= y + CNT_W'(1);
                        y_acc <= y_acc + cys;
                        if (last_y) state <= DRAIN;
                    end
                end
                DRAIN: if (can_load) state <= FIN;
                FIN: state <= IDLE;
            endcase
        end
    end

`ifdef AFFINE_SCAN_WR_LAST_CHECK_EN
    // Sticky flag for a beat whose in_last disagrees with the frame position; cleared by a new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (accept && (in_last != (last_x && last_y))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_affine_scan_writer.sv
// tb_affine_scan_writer: table of frames driven through the writer with a write-address scoreboard
module tb_affine_scan_writer;

    logic        clk, rst_n, start, in_valid, in_ready, wr_valid, wr_ready, busy, done;
    logic [15:0] x_max, y_max, x_stride, y_stride, offset, in_data, wr_addr, wr_data;
`ifdef AFFINE_SCAN_WR_LAST_CHECK_EN
    logic        in_last, err;
`endif

    typedef struct {
        logic [15:0] xm, ym, xs, ys, off;
        int          rmode;
        int          exp_done;
        logic        lmode;
    } frame_t;

    frame_t      tbl[8];
    logic [31:0] q[$];
    int          total, bad;

    affine_scan_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x_max    (x_max),
        .y_max    (y_max),
        .x_stride (x_stride),
        .y_stride (y_stride),
        .offset   (offset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
`ifdef AFFINE_SCAN_WR_LAST_CHECK_EN
        ,
        .in_last  (in_last),
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one frame starting at the current cycle; the model walks x/y directly rather than accumulating.
    task automatic run_frame(input frame_t f);
        logic [15:0] mx, my, dcnt, ea, ha, hd;
        logic [31:0] e;
        logic        hv, done_seen;
        int          nwr, nbusy, c;
        mx = 0; my = 0; dcnt = 0; hv = 0; done_seen = 0; nwr = 0; nbusy = 0;
        x_max = f.xm; y_max = f.ym; x_stride = f.xs; y_stride = f.ys; offset = f.off;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hD000;
        wr_ready = (f.rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef AFFINE_SCAN_WR_LAST_CHECK_EN
        in_last = f.lmode ? 1'b0 : (f.xm == 16'd1 && f.ym == 16'd1);
`endif
        for (c = 0; c < 500; c++) begin
            #1;
            if (c == 0) check("in_ready_at_start", in_ready, 0);
            if (c == 1) check("busy_after_start", busy, 1);
            if (hv) check("hold_stable", {wr_valid, wr_addr, wr_data}, {1'b1, ha, hd});
            hv = wr_valid && !wr_ready;
            ha = wr_addr;
            hd = wr_data;
            if (wr_valid && wr_ready) begin
                nwr++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write got addr=%0h expected no write", wr_addr);
                end else begin
                    e = q.pop_front();
                    check("wr_addr", wr_addr, e[31:16]);
                    check("wr_data", wr_data, e[15:0]);
                end
            end
            if (in_valid && in_ready) begin
                ea = f.off + mx * f.xs + my * f.ys;
                q.push_back({ea, in_data});
                dcnt++;
                if (mx == f.xm - 16'd1) begin
                    mx = 0;
                    my++;
                end else begin
                    mx++;
                end
            end
            if (busy) nbusy++;
            if (done) begin
                done_seen = 1;
                break;
            end
            @(posedge clk);
            #1;
            start = (c + 1 == 3) && (f.xm * f.ym >= 16'd4);
            x_max = start ? 16'd2 : f.xm;
            offset = start ? 16'h0 : f.off;
            in_valid = (f.rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = 16'hD000 ^ (dcnt * 16'h0111);
            wr_ready = (f.rmode == 0) ? 1'b1 : (f.rmode == 1) ? ((c + 1) % 2 == 0) : 1'($urandom_range(0, 1));
`ifdef AFFINE_SCAN_WR_LAST_CHECK_EN
            in_last = f.lmode ? (dcnt == 16'd1) : (mx == f.xm - 16'd1 && my == f.ym - 16'd1);
`endif
        end
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout got no done within %0d cycles expected done", c);
        end else begin
            if (f.exp_done >= 0) check("done_cycle", c, f.exp_done);
            check("busy_cycles", nbusy, c - 1);
            check("write_count", nwr, f.xm * f.ym);
            check("queue_empty", q.size(), 0);
`ifdef AFFINE_SCAN_WR_LAST_CHECK_EN
            check("err", err, f.lmode);
`endif
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wr_ready = 1'b1;
        #1;
        check("done_single_pulse", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        tbl[0] = '{16'd4, 16'd3, 16'd1, 16'd16, 16'h0100, 0, 14, 1'b0};
        tbl[1] = '{16'd4, 16'd3, 16'd1, 16'd16, 16'h0100, 1, -1, 1'b0};
        tbl[2] = '{16'd0, 16'd5, 16'd1, 16'd1, 16'h0010, 0, 2, 1'b0};
        tbl[3] = '{16'd4, 16'd1, 16'd8, 16'd0, 16'hFFF0, 0, 6, 1'b0};
        tbl[4] = '{16'd2, 16'd2, 16'd1, 16'h0010, 16'h0200, 0, 6, 1'b1};
        tbl[5] = '{16'd3, 16'd2, 16'd7, 16'h0100, 16'h0020, 2, -1, 1'b0};
        tbl[6] = '{16'd1, 16'd1, 16'd3, 16'd3, 16'h0055, 0, 3, 1'b0};
        tbl[7] = '{16'd5, 16'd0, 16'd1, 16'd1, 16'h0000, 0, 2, 1'b0};
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0; in_data = '0;
        x_max = '0; y_max = '0; x_stride = '0; y_stride = '0; offset = '0;
`ifdef AFFINE_SCAN_WR_LAST_CHECK_EN
        in_last = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {in_ready, wr_valid, busy, done, wr_addr, wr_data}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) run_frame(tbl[i]);
        x_max = 16'd4; y_max = 16'd4; x_stride = 16'd1; y_stride = 16'd4; offset = 16'h0000;
        start = 1'b1; in_valid = 1'b1; wr_ready = 1'b1; in_data = 16'h5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_active", {busy, wr_valid}, 2'b11);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_outputs", {in_ready, wr_valid, busy, done, wr_addr, wr_data}, 0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        q.delete();
        run_frame('{16'd2, 16'd2, 16'd1, 16'd4, 16'h0300, 0, 6, 1'b0});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
